// File: rtl/ascii_uart_tx.sv
// Byte FIFO feeding an 8N1 UART transmitter; carries the message generator's
// characters out to a serial terminal on a single idle-high pin.
module ascii_uart_tx #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          tx,
  output logic          busy,
  output logic [CW-1:0] fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    fifoMem_q [FIFO_DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q, state_d;
  logic [15:0]   baudCnt_q, baudCnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          push, pop, bitEnd;

  assign in_ready   = count_q < CW'(FIFO_DEPTH);
  assign push       = in_valid && in_ready;
  assign bitEnd     = baudCnt_q == BAUD_LAST;
  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign fifo_count = count_q;

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) fifoMem_q[wrPtr_q] <= in_data;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      baudCnt_q <= '0;
      bitIdx_q  <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      count_q   <= count_d;
      state_q   <= state_d;
      baudCnt_q <= baudCnt_d;
      bitIdx_q  <= bitIdx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  // tx_d is the level for the coming bit period, so tx stays a clean flop output.
  always_comb begin
    state_d   = state_q;
    baudCnt_d = baudCnt_q;
    bitIdx_d  = bitIdx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop       = 1'b1;
          shift_d   = fifoMem_q[rdPtr_q];
          baudCnt_d = '0;
          state_d   = START;
          tx_d      = 1'b0;
        end
      end
      START: begin
        if (bitEnd) begin
          baudCnt_d = '0;
          bitIdx_d  = '0;
          state_d   = DATA;
          tx_d      = shift_q[0];
        end else begin
          baudCnt_d = baudCnt_q + 16'd1;
        end
      end
      DATA: begin
        if (bitEnd) begin
          baudCnt_d = '0;
          if (bitIdx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d  = shift_q >> 1;
            bitIdx_d = bitIdx_q + 3'd1;
            tx_d     = shift_q[1];
          end
        end else begin
          baudCnt_d = baudCnt_q + 16'd1;
        end
      end
      STOP: begin
        if (bitEnd) begin
          baudCnt_d = '0;
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = fifoMem_q[rdPtr_q];
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baudCnt_d = baudCnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_ascii_uart_tx.sv
// Randomised bench for ascii_uart_tx: two instances (CLK_DIV 4 and 2) compared
// cycle by cycle against a frame-level model of the FIFO and the serial line.
module tb_ascii_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] inData;
  logic       inValid;
  logic       sel;
  logic       valid4, valid2;
  logic       ready4, tx4, busy4, ready2, tx2, busy2;
  logic [2:0] count4, count2;

  assign valid4 = inValid & ~sel;
  assign valid2 = inValid & sel;

  ascii_uart_tx #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(inData), .in_valid(valid4),
    .in_ready(ready4), .tx(tx4), .busy(busy4), .fifo_count(count4)
  );

  ascii_uart_tx #(.CLK_DIV(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(inData), .in_valid(valid2),
    .in_ready(ready2), .tx(tx2), .busy(busy2), .fifo_count(count2)
  );

  logic       obsTx, obsReady, obsBusy;
  logic [2:0] obsCount;
  logic [5:0] obsVec, expVec;

  assign obsTx    = sel ? tx2 : tx4;
  assign obsReady = sel ? ready2 : ready4;
  assign obsBusy  = sel ? busy2 : busy4;
  assign obsCount = sel ? count2 : count4;
  assign obsVec   = {obsTx, obsReady, obsBusy, obsCount};

  // Model: a byte queue plus the start edge of the frame on the line.
  logic [7:0] mQ[$];
  logic [7:0] curByte;
  int         t, frameStart, nextLoad, div, sizeBefore;
  bit         active, mPush, mPop;
  int         errors = 0;
  int         checks = 0;

  function automatic logic frameBit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic modelReset();
    mQ.delete();
    active   = 1'b0;
    nextLoad = 0;
  endtask

  task automatic tick();
    logic [7:0] d;
    d          = inData;
    sizeBefore = mQ.size();
    mPush      = inValid && (sizeBefore < 4);
    mPop       = (t + 1 >= nextLoad) && (sizeBefore > 0);
    @(posedge clk);
    t++;
    if (mPop) begin
      curByte    = mQ.pop_front();
      frameStart = t;
      active     = 1'b1;
      nextLoad   = t + 10 * div;
    end
    if (mPush) mQ.push_back(d);
    if (active && t >= frameStart + 10 * div) active = 1'b0;
    expVec = {active ? frameBit(curByte, (t - frameStart) / div) : 1'b1,
              mQ.size() < 4, active || (mQ.size() != 0), 3'(mQ.size())};
    #1;
  endtask

  task automatic test_reset();
    sel = 1'b0; inValid = 1'b0; inData = 8'h00; div = 4; t = 0;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    #2;
    checks++;
    if ({tx4, ready4, busy4, count4} !== 6'b110000) begin
      errors++; $display("[TB] FAIL reset_div4 got=%b exp=110000", {tx4, ready4, busy4, count4});
    end
    checks++;
    if ({tx2, ready2, busy2, count2} !== 6'b110000) begin
      errors++; $display("[TB] FAIL reset_div2 got=%b exp=110000", {tx2, ready2, busy2, count2});
    end
    inValid = 1'b1; inData = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obsVec !== 6'b110000) begin
      errors++; $display("[TB] FAIL reset_held got=%b exp=110000", obsVec);
    end
    inValid = 1'b0;
    rst_n = 1'b0;
    modelReset();
  endtask

  task automatic test_single();
    inData = 8'h41; inValid = 1'b1;
    tick();
    inValid = 1'b0;
    checks++;
    if (obsVec !== expVec) begin
      errors++; $display("[TB] FAIL single_push t=%0d got=%b exp=%b", t, obsVec, expVec);
    end
    tick();
    checks++;
    if (obsTx !== 1'b0) begin
      errors++; $display("[TB] FAIL single_latency got=%b exp=0", obsTx);
    end
    for (int c = 0; c < 42; c++) begin
      checks++;
      if (obsVec !== expVec) begin
        errors++; $display("[TB] FAIL single_frame t=%0d got=%b exp=%b", t, obsVec, expVec);
      end
      tick();
    end
    checks++;
    if ({obsTx, obsBusy} !== 2'b10) begin
      errors++; $display("[TB] FAIL single_idle got=%b exp=10", {obsTx, obsBusy});
    end
  endtask

  task automatic test_stream();
    logic [7:0] msg [6] = '{8'h53, 8'h6F, 8'h79, 8'h20, 8'h64, 8'h65};
    int idx = 0;
    int frames = 0;
    bit sawFull = 1'b0;
    inValid = 1'b1; inData = msg[0];
    for (int c = 0; c < 260; c++) begin
      tick();
      if (mPop) frames++;
      if (mPush) begin
        idx++;
        if (idx == 6) inValid = 1'b0;
        else inData = msg[idx];
      end
      checks++;
      if (obsVec !== expVec) begin
        errors++; $display("[TB] FAIL stream t=%0d got=%b exp=%b", t, obsVec, expVec);
      end
      if (obsCount == 3'd4 && obsReady == 1'b0) sawFull = 1'b1;
    end
    checks++;
    if ({sawFull, idx == 6, frames == 6} !== 3'b111) begin
      errors++; $display("[TB] FAIL stream_totals got full=%0d pushed=%0d frames=%0d exp 1/6/6", sawFull, idx, frames);
    end
  endtask

  task automatic test_full_pop();
    bit seen = 1'b0;
    inValid = 1'b1; inData = 8'($urandom);
    for (int c = 0; c < 230; c++) begin
      tick();
      if (mPush) inData = 8'($urandom);
      checks++;
      if (obsVec !== expVec) begin
        errors++; $display("[TB] FAIL full_pop t=%0d got=%b exp=%b", t, obsVec, expVec);
      end
      if (mPop && sizeBefore == 4 && !seen) begin
        seen = 1'b1;
        inValid = 1'b0;
        checks++;
        if ({obsCount, obsReady} !== {3'd3, 1'b1}) begin
          errors++; $display("[TB] FAIL full_pop_edge got count=%0d ready=%b exp count=3 ready=1", obsCount, obsReady);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("[TB] FAIL full_pop_reached got=0 exp=1");
    end
  endtask

  task automatic test_pop_push_count1();
    bit hit = 1'b0;
    inValid = 1'b1; inData = 8'($urandom);
    tick();
    inData = 8'($urandom);
    tick();
    inValid = 1'b0;
    for (int c = 0; c < 130; c++) begin
      if (!hit && t + 1 == nextLoad) begin
        inValid = 1'b1; inData = 8'($urandom);
      end
      tick();
      inValid = 1'b0;
      checks++;
      if (obsVec !== expVec) begin
        errors++; $display("[TB] FAIL count1 t=%0d got=%b exp=%b", t, obsVec, expVec);
      end
      if (mPop && mPush && sizeBefore == 1 && !hit) begin
        hit = 1'b1;
        checks++;
        if (obsCount !== 3'd1) begin
          errors++; $display("[TB] FAIL count1_edge got=%0d exp=1", obsCount);
        end
      end
    end
    checks++;
    if (!hit) begin
      errors++; $display("[TB] FAIL count1_reached got=0 exp=1");
    end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    inData = 8'hE1; inValid = 1'b1;
    tick();
    inValid = 1'b0;
    // Data bit 3 is frame bit 4; stop one cycle into it.
    while (!(active && t == frameStart + 4 * div + 1) && c < 60) begin
      checks++;
      if (obsVec !== expVec) begin
        errors++; $display("[TB] FAIL midreset_pre t=%0d got=%b exp=%b", t, obsVec, expVec);
      end
      tick();
      c++;
    end
    checks++;
    if (obsTx !== 1'b0 || c >= 60) begin
      errors++; $display("[TB] FAIL midreset_bit3 got tx=%b cycles=%0d exp tx=0", obsTx, c);
    end
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (obsVec !== 6'b110000) begin
      errors++; $display("[TB] FAIL midreset_async got=%b exp=110000", obsVec);
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    modelReset();
    inData = 8'h21; inValid = 1'b1;
    tick();
    inValid = 1'b0;
    for (int k = 0; k < 44; k++) begin
      checks++;
      if (obsVec !== expVec) begin
        errors++; $display("[TB] FAIL midreset_after t=%0d got=%b exp=%b", t, obsVec, expVec);
      end
      tick();
    end
  endtask

  task automatic test_div2();
    sel = 1'b1; div = 2;
    modelReset();
    inData = 8'h00; inValid = 1'b1;
    tick();
    inData = 8'hFF;
    tick();
    inValid = 1'b0;
    for (int c = 0; c < 46; c++) begin
      checks++;
      if (obsVec !== expVec) begin
        errors++; $display("[TB] FAIL div2 t=%0d got=%b exp=%b", t, obsVec, expVec);
      end
      tick();
    end
    sel = 1'b0; div = 4;
    modelReset();
  endtask

  task automatic test_random();
    inValid = 1'b0;
    for (int c = 0; c < 850; c++) begin
      if (c >= 600) inValid = 1'b0;
      else if (!inValid) begin
        inValid = (c < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
        inData  = 8'($urandom);
      end
      tick();
      if (mPush) begin
        inValid = 1'($urandom_range(0, 1));
        inData  = 8'($urandom);
      end
      checks++;
      if (obsVec !== expVec) begin
        errors++; $display("[TB] FAIL random t=%0d got=%b exp=%b", t, obsVec, expVec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_full_pop();
    test_pop_push_count1();
    test_reset_mid();
    test_div2();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ascii_uart_tx.md
Name: ascii_uart_tx

Overview:
- Downstream consumer of the ASCII message generator's byte stream: buffers characters in a small FIFO and serializes them as 8N1 UART frames on a single pin.
- Upstream advances its character index only on an accepted handshake (in_valid && in_ready), so no character is dropped or repeated.
- Output pin drives a TinyTapeout uio/uo bit toward an external serial terminal.

Parameters:
- CLK_DIV, 16, clk cycles per UART bit; legal range 2..65535.
- FIFO_DEPTH, 4, FIFO entries; power of two, 2..16.
- CW, $clog2(FIFO_DEPTH)+1, width of fifo_count; derived, not overridden.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-high
- in_data  input  8  ASCII byte from the message generator
- in_valid  input  1  in_data valid this cycle
- in_ready  output  1  FIFO can accept a byte this cycle
- tx  output  1  UART serial line, idle high
- busy  output  1  frame in progress or FIFO non-empty
- fifo_count  output  CW  bytes currently buffered

Behaviour:
- Reset (rst_n=1, async): state=IDLE, tx=1, FIFO pointers and count=0, baud counter=0, bit index=0.
  - Outputs during reset: in_ready=1, busy=0, fifo_count=0.
  - Reset mid-frame aborts the frame immediately, and tx returns to 1 without waiting for a clock edge.
  - Buffered bytes are discarded.
- FIFO:
  - in_ready = (count < FIFO_DEPTH), combinational from registered count.
  - Push occurs on a rising edge when in_valid && in_ready.
  - Pop occurs only when the TX FSM loads a byte.
  - Push and pop in the same cycle leave count unchanged; data order is preserved.
  - When full, in_ready=0 even if a pop happens that cycle; there is no fall-through path.
  - When empty, a push is not bypassed to the shifter; it is poppable from the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - in_data is ignored when in_valid=0, or when in_valid=1 and in_ready=0; upstream holds it.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If count!=0, pop head into the 8-bit shift register, clear the baud counter, go to START.
  - START: tx=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Each bit lasts CLK_DIV cycles, then shift right and increment the index. After bit 7 completes, go to STOP.
  - STOP: tx=1 for CLK_DIV cycles. At the end, if count!=0, pop and go directly to START with no idle cycle; else go to IDLE.
- tx is a registered output; it is the value of the current state/bit.
- Baud counter runs 0..CLK_DIV-1 and wraps at the bit boundary.
- Frame length is exactly 10*CLK_DIV cycles.
- Back-to-back frames have no gap between the STOP bit and the next START bit.
- Latency: a byte accepted at edge E, with the FSM in IDLE and the FIFO previously empty, drives tx=0 after edge E+1.
- busy = (state!=IDLE) || (count!=0), combinational from registers.
- Bytes are transmitted unmodified, including 0x00 and bytes with bit 7 set (e.g. 0xE1, 0xA1).

Test Plan:
- CLK_DIV=4, single push 0x41 -> tx=0 from edge E+1.
  - Then tx holds 0,1,0,0,0,0,0,1,0,1, each for exactly 4 cycles.
  - Then tx=1 and busy=0.
- CLK_DIV=4, in_valid held high with 6 bytes "Soy de" (0x53,0x6F,0x79,0x20,0x64,0x65):
  - in_ready drops while count=4.
  - All 6 frames are contiguous (240 cycles, no idle bit) and arrive in order.
  - No byte is lost or duplicated.
- FIFO full (count=4) with in_valid=1 and a pop on the same edge -> push not accepted; count becomes 3; in_ready=1 next cycle.
- count=1 during a STOP-end pop with a simultaneous push -> count stays 1; the pushed byte is the next frame.
- Assert rst_n during DATA bit 3 of frame 0xE1:
  - tx=1 immediately (asynchronous).
  - fifo_count=0, busy=0.
  - After release, a new push of 0x21 produces a clean full frame.
- CLK_DIV=2, push 0x00 and 0xFF back-to-back -> frames are 0 + eight 0s + 1, then 0 + eight 1s + 1, each bit exactly 2 cycles.
